// File: rtl/billiard_pkg.sv
// rtl/billiard_pkg.sv - shared types, widths and helpers for the billiard shot controller
package billiard_pkg;

    localparam int VEL_W       = 11;
    localparam int FRAME_CNT_W = 10;
    localparam int STILL_CNT_W = 3;

    typedef enum logic [2:0] {
        AIM,
        FIRE,
        ROLLING,
        RESOLVE,
        GAME_OVER
    } shot_state_t;

    // Clamp one signed velocity axis to [-lim, +lim]; the sign is preserved.
    function automatic logic signed [VEL_W-1:0] clamp_vel(
        input logic signed [VEL_W-1:0] v,
        input logic signed [VEL_W-1:0] lim
    );
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/still_detector.sv
// rtl/still_detector.sv - counts still frames and rolling frames, flags end of shot
//  clk_i, clear_i        clock, synchronous clear (counters and skip flag)
//  enable_i              counting allowed (table is rolling)
//  start_of_frame_i      one-cycle frame pulse
//  white_vel_*_i, red_vel_*_i   ball velocities
//  white_mask_i, red_mask_i     ball pocketed: its velocity counts as zero
//  done_o                this frame ends the shot (still streak or timeout)
module still_detector
    import billiard_pkg::*;
#(
    parameter int STOP_FRAMES     = 4,
    parameter int MAX_ROLL_FRAMES = 1023
) (
    input  logic                    clk_i,
    input  logic                    clear_i,
    input  logic                    enable_i,
    input  logic                    start_of_frame_i,
    input  logic signed [VEL_W-1:0] white_vel_x_i,
    input  logic signed [VEL_W-1:0] white_vel_y_i,
    input  logic signed [VEL_W-1:0] red_vel_x_i,
    input  logic signed [VEL_W-1:0] red_vel_y_i,
    input  logic                    white_mask_i,
    input  logic                    red_mask_i,
    output logic                    done_o
);

    logic                   armed_q, armed_d;
    logic [STILL_CNT_W-1:0] still_cnt_q, still_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   white_still, red_still, table_still;

    always_comb begin
        white_still = ((white_vel_x_i == '0) && (white_vel_y_i == '0)) || white_mask_i;
        red_still   = ((red_vel_x_i == '0) && (red_vel_y_i == '0)) || red_mask_i;
        table_still = white_still && red_still;

        armed_d     = armed_q;
        still_cnt_d = still_cnt_q;
        frame_cnt_d = frame_cnt_q;
        done_o      = 1'b0;

        if (enable_i && start_of_frame_i) begin
            // The first frame after the cue hit is skipped: the mover has not
            // yet applied the loaded velocity, so the table still looks still.
            if (!armed_q) begin
                armed_d = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                still_cnt_d = table_still ? still_cnt_q + STILL_CNT_W'(1) : '0;
                done_o      = (still_cnt_d == STILL_CNT_W'(STOP_FRAMES)) ||
                              (frame_cnt_d == FRAME_CNT_W'(MAX_ROLL_FRAMES));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            armed_q     <= 1'b0;
            still_cnt_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            armed_q     <= armed_d;
            still_cnt_q <= still_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/shot_sequencer.sv
// rtl/shot_sequencer.sv - turn/shot controller for the two-ball table
//  clk, reset                     clock, synchronous active-high reset
//  startOfFrame                   frame pulse
//  shotReq                        shoot button level, edge detected here
//  cueVelX/Y                      aim vector
//  whiteBallVelX/Y, redBallVelX/Y ball velocities
//  whiteBallHoleHit, redBallHoleHit  pocket events
//  whiteLoadVel, whiteVelXOut/Y   cue velocity load pulse and clamped value
//  whiteRespawn, redRespawn       respawn pulses
//  redHide                        red pocketed, not drawn
//  aimEnable, gameOver            state indications
//  currentPlayer, score0, score1  turn and scores
module shot_sequencer
    import billiard_pkg::*;
#(
    parameter int MAX_SHOT_SPEED  = 8,
    parameter int STOP_FRAMES     = 4,
    parameter int MAX_ROLL_FRAMES = 1023,
    parameter int SCORE_W         = 4,
    parameter int WIN_SCORE       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    shotReq,
    input  logic signed [VEL_W-1:0] cueVelX,
    input  logic signed [VEL_W-1:0] cueVelY,
    input  logic signed [VEL_W-1:0] whiteBallVelX,
    input  logic signed [VEL_W-1:0] whiteBallVelY,
    input  logic signed [VEL_W-1:0] redBallVelX,
    input  logic signed [VEL_W-1:0] redBallVelY,
    input  logic                    whiteBallHoleHit,
    input  logic                    redBallHoleHit,
    output logic                    whiteLoadVel,
    output logic signed [VEL_W-1:0] whiteVelXOut,
    output logic signed [VEL_W-1:0] whiteVelYOut,
    output logic                    whiteRespawn,
    output logic                    redRespawn,
    output logic                    redHide,
    output logic                    aimEnable,
    output logic                    currentPlayer,
    output logic [SCORE_W-1:0]      score0,
    output logic [SCORE_W-1:0]      score1,
    output logic                    gameOver
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    shot_state_t        state_q, state_d;
    logic               shot_req_q;
    logic               white_pkt_q, white_pkt_d;
    logic               red_pkt_q, red_pkt_d;
    logic               player_q, player_d;
    logic [SCORE_W-1:0] score0_q, score0_d;
    logic [SCORE_W-1:0] score1_q, score1_d;

    logic                    shot_edge;
    logic                    rolling;
    logic                    roll_done;
    logic signed [VEL_W-1:0] clamped_x, clamped_y;
    logic [SCORE_W-1:0]      cur_score, inc_score;

    assign shot_edge = shotReq & ~shot_req_q;
    assign rolling   = (state_q == ROLLING);
    assign clamped_x = clamp_vel(cueVelX, VEL_W'(MAX_SHOT_SPEED));
    assign clamped_y = clamp_vel(cueVelY, VEL_W'(MAX_SHOT_SPEED));
    assign cur_score = player_q ? score1_q : score0_q;
    assign inc_score = (cur_score == SCORE_MAX) ? cur_score : cur_score + SCORE_W'(1);

    // A pocket event in the same cycle as the frame pulse already masks that
    // ball, hence the live hole input is OR-ed with the sticky flag.
    still_detector #(
        .STOP_FRAMES     (STOP_FRAMES),
        .MAX_ROLL_FRAMES (MAX_ROLL_FRAMES)
    ) u_still (
        .clk_i            (clk),
        .clear_i          (reset || !rolling),
        .enable_i         (rolling),
        .start_of_frame_i (startOfFrame),
        .white_vel_x_i    (whiteBallVelX),
        .white_vel_y_i    (whiteBallVelY),
        .red_vel_x_i      (redBallVelX),
        .red_vel_y_i      (redBallVelY),
        .white_mask_i     (white_pkt_q || whiteBallHoleHit),
        .red_mask_i       (red_pkt_q || redBallHoleHit),
        .done_o           (roll_done)
    );

    always_comb begin
        state_d      = state_q;
        white_pkt_d  = white_pkt_q;
        red_pkt_d    = red_pkt_q;
        player_d     = player_q;
        score0_d     = score0_q;
        score1_d     = score1_q;
        whiteLoadVel = 1'b0;
        whiteVelXOut = '0;
        whiteVelYOut = '0;
        whiteRespawn = 1'b0;
        redRespawn   = 1'b0;

        case (state_q)
            AIM: begin
                if (shot_edge) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                // A zero cue vector after clamping is a non-shot: back to aiming
                // without consuming the turn.
                if ((clamped_x == '0) && (clamped_y == '0)) begin
                    state_d = AIM;
                end else begin
                    whiteLoadVel = 1'b1;
                    whiteVelXOut = clamped_x;
                    whiteVelYOut = clamped_y;
                    state_d      = ROLLING;
                end
            end
            ROLLING: begin
                if (whiteBallHoleHit) begin
                    white_pkt_d = 1'b1;
                end
                if (redBallHoleHit) begin
                    red_pkt_d = 1'b1;
                end
                if (roll_done) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                white_pkt_d = 1'b0;
                red_pkt_d   = 1'b0;
                state_d     = AIM;
                if (white_pkt_q) begin
                    whiteRespawn = 1'b1;
                    redRespawn   = red_pkt_q;
                    player_d     = ~player_q;
                end else if (red_pkt_q) begin
                    redRespawn = 1'b1;
                    if (player_q) begin
                        score1_d = inc_score;
                    end else begin
                        score0_d = inc_score;
                    end
                    if (inc_score >= SCORE_W'(WIN_SCORE)) begin
                        state_d = GAME_OVER;
                    end
                end else begin
                    player_d = ~player_q;
                end
            end
            GAME_OVER: begin
                if (shot_edge) begin
                    score0_d     = '0;
                    score1_d     = '0;
                    player_d     = 1'b0;
                    whiteRespawn = 1'b1;
                    redRespawn   = 1'b1;
                    state_d      = AIM;
                end
            end
            default: begin
                state_d = AIM;
            end
        endcase

        // Reset suppresses every pulse in the cycle it is asserted.
        if (reset) begin
            whiteLoadVel = 1'b0;
            whiteVelXOut = '0;
            whiteVelYOut = '0;
            whiteRespawn = 1'b0;
            redRespawn   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= AIM;
            shot_req_q  <= 1'b0;
            white_pkt_q <= 1'b0;
            red_pkt_q   <= 1'b0;
            player_q    <= 1'b0;
            score0_q    <= '0;
            score1_q    <= '0;
        end else begin
            state_q     <= state_d;
            shot_req_q  <= shotReq;
            white_pkt_q <= white_pkt_d;
            red_pkt_q   <= red_pkt_d;
            player_q    <= player_d;
            score0_q    <= score0_d;
            score1_q    <= score1_d;
        end
    end

    // The sticky red flag is exactly the hide condition: set the cycle after
    // the first red pocket event, cleared when the shot resolves.
    assign redHide       = red_pkt_q;
    assign aimEnable     = (state_q == AIM);
    assign gameOver      = (state_q == GAME_OVER);
    assign currentPlayer = player_q;
    assign score0        = score0_q;
    assign score1        = score1_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// tb/tb_shot_sequencer.sv - self-checking bench for shot_sequencer
module tb_shot_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               startOfFrame, shotReq;
    logic signed [10:0] cueVelX, cueVelY;
    logic signed [10:0] whiteBallVelX, whiteBallVelY, redBallVelX, redBallVelY;
    logic               whiteBallHoleHit, redBallHoleHit;
    logic               whiteLoadVel, whiteRespawn, redRespawn, redHide;
    logic               aimEnable, currentPlayer, gameOver;
    logic signed [10:0] whiteVelXOut, whiteVelYOut;
    logic [3:0]         score0, score1;

    shot_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .startOfFrame     (startOfFrame),
        .shotReq          (shotReq),
        .cueVelX          (cueVelX),
        .cueVelY          (cueVelY),
        .whiteBallVelX    (whiteBallVelX),
        .whiteBallVelY    (whiteBallVelY),
        .redBallVelX      (redBallVelX),
        .redBallVelY      (redBallVelY),
        .whiteBallHoleHit (whiteBallHoleHit),
        .redBallHoleHit   (redBallHoleHit),
        .whiteLoadVel     (whiteLoadVel),
        .whiteVelXOut     (whiteVelXOut),
        .whiteVelYOut     (whiteVelYOut),
        .whiteRespawn     (whiteRespawn),
        .redRespawn       (redRespawn),
        .redHide          (redHide),
        .aimEnable        (aimEnable),
        .currentPlayer    (currentPlayer),
        .score0           (score0),
        .score1           (score1),
        .gameOver         (gameOver)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected pulses keyed by cycle number; expected levels as plain variables.
    int e_wl[int];
    int e_vx[int];
    int e_vy[int];
    int e_wr[int];
    int e_rr[int];
    int m_s0, m_s1, m_p, m_go, m_aim, m_hide;
    bit m_valid = 1'b0;
    int n_loads = 0;
    int last_vx = 0;
    int last_vy = 0;

    always @(negedge clk) begin
        chk("whiteLoadVel", int'(whiteLoadVel), e_wl.exists(cyc));
        chk("whiteVelXOut", int'(whiteVelXOut), e_vx.exists(cyc) ? e_vx[cyc] : 0);
        chk("whiteVelYOut", int'(whiteVelYOut), e_vy.exists(cyc) ? e_vy[cyc] : 0);
        chk("whiteRespawn", int'(whiteRespawn), e_wr.exists(cyc));
        chk("redRespawn", int'(redRespawn), e_rr.exists(cyc));
        if (m_valid) begin
            chk("score0", int'(score0), m_s0);
            chk("score1", int'(score1), m_s1);
            chk("currentPlayer", int'(currentPlayer), m_p);
            chk("gameOver", int'(gameOver), m_go);
            chk("aimEnable", int'(aimEnable), m_aim);
            chk("redHide", int'(redHide), m_hide);
        end
        if (whiteLoadVel) begin
            n_loads++;
            last_vx = int'(whiteVelXOut);
            last_vy = int'(whiteVelYOut);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        startOfFrame     = 1'b0;
        shotReq          = 1'b0;
        whiteBallVelX    = '0;
        whiteBallVelY    = '0;
        redBallVelX      = '0;
        redBallVelY      = '0;
        whiteBallHoleHit = 1'b0;
        redBallHoleHit   = 1'b0;
    endtask

    task automatic model_reset;
        m_s0 = 0; m_s1 = 0; m_p = 0; m_go = 0; m_aim = 1; m_hide = 0;
    endtask

    task automatic do_reset(input int n);
        m_valid = 1'b0;
        reset   = 1'b1;
        idle_inputs();
        repeat (n) tick();
        reset = 1'b0;
        model_reset();
        m_valid = 1'b1;
    endtask

    function automatic int clampv(input int v);
        return (v > 8) ? 8 : ((v < -8) ? -8 : v);
    endfunction

    // Shot edge in the current cycle; FIRE is the next cycle.
    task automatic shoot(input int cx, input int cy);
        int c;
        int ex, ey;
        bit nz;
        c  = cyc;
        ex = clampv(cx);
        ey = clampv(cy);
        nz = (ex != 0) || (ey != 0);
        cueVelX = 11'(cx);
        cueVelY = 11'(cy);
        shotReq = 1'b1;
        if (nz) begin
            e_wl[c+1] = 1; e_vx[c+1] = ex; e_vy[c+1] = ey;
        end
        tick();
        m_aim = 0;
        tick();
        if (!nz) m_aim = 1;
    endtask

    // Drives a rolling table with frames every 4 cycles. Balls that are
    // pocketed keep a nonzero velocity so that masking is exercised.
    task automatic roll(input int moving_frames, input bit wpk, input bit rpk,
                        input int pk_start, input int req_hold, input int abort_at);
        bit wf = 0, rf = 0, first = 1, done = 0, sof, wh, rh;
        int fc = 0, streak = 0, k = 0, f, wv, rv;
        int ns0, ns1, np, ngo;
        while (!done) begin
            if (abort_at >= 0 && k == abort_at) return;
            f   = k / 4;
            sof = (k % 4 == 0);
            wh  = wpk && k >= pk_start && k < pk_start + 5;
            rh  = rpk && k >= pk_start && k < pk_start + 5;
            wv  = (f < moving_frames || wpk) ? 5 : 0;
            rv  = (f < moving_frames || rpk) ? 7 : 0;
            startOfFrame     = sof;
            whiteBallVelX    = 11'(wv);
            whiteBallVelY    = '0;
            redBallVelX      = '0;
            redBallVelY      = 11'(rv);
            whiteBallHoleHit = wh;
            redBallHoleHit   = rh;
            shotReq          = (k < req_hold);
            wf = wf | wh;
            rf = rf | rh;
            if (sof) begin
                if (first) first = 0;
                else begin
                    fc++;
                    streak = (((wv == 0) || wf) && ((rv == 0) || rf)) ? streak + 1 : 0;
                    if (streak == 4 || fc == 1023) done = 1;
                end
            end
            tick();
            k++;
            m_hide = rf;
        end
        idle_inputs();
        if (wf) e_wr[cyc] = 1;
        if (rf) e_rr[cyc] = 1;
        ns0 = m_s0; ns1 = m_s1; np = m_p; ngo = 0;
        if (wf) np = m_p ^ 1;
        else if (rf) begin
            if (m_p == 0) begin ns0 = (m_s0 < 15) ? m_s0 + 1 : 15; ngo = (ns0 >= 3); end
            else begin ns1 = (m_s1 < 15) ? m_s1 + 1 : 15; ngo = (ns1 >= 3); end
        end else np = m_p ^ 1;
        tick();
        m_s0 = ns0; m_s1 = ns1; m_p = np; m_go = ngo; m_aim = !ngo; m_hide = 0;
    endtask

    task automatic restart_game;
        int c;
        c = cyc;
        shotReq = 1'b1;
        e_wr[c] = 1;
        e_rr[c] = 1;
        tick();
        model_reset();
        shotReq = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int saved;
        reset   = 1'b1;
        cueVelX = '0;
        cueVelY = '0;
        idle_inputs();
        model_reset();
        do_reset(3);
        chk("reset score0", int'(score0), 0);
        chk("reset aimEnable", int'(aimEnable), 1);
        chk("reset gameOver", int'(gameOver), 0);
        chk("reset player", int'(currentPlayer), 0);
        tick();

        // 1: clamp on X, button held for 10 cycles fires once
        shoot(20, -3);
        chk("t1 rolling aim low", int'(aimEnable), 0);
        roll(2, 0, 0, 0, 8, -1);
        tick();
        chk("t1 load count", n_loads, 1);
        chk("t1 vx clamped", last_vx, 8);
        chk("t1 vy", last_vy, -3);
        chk("t1 turn passed", int'(currentPlayer), 1);

        // 2: zero cue vector is a non-shot
        shoot(0, 0);
        shotReq = 1'b0;
        tick();
        chk("t2 no load", n_loads, 1);
        chk("t2 player kept", int'(currentPlayer), 1);
        chk("t2 back in aim", int'(aimEnable), 1);

        shoot(3, 0);
        roll(1, 0, 0, 0, 0, -1);
        tick();
        chk("turn back to p0", int'(currentPlayer), 0);

        // 3: red pocketed across a frame pulse
        shoot(-9, 9);
        roll(1, 0, 1, 6, 0, -1);
        tick();
        chk("t3 vx clamped", last_vx, -8);
        chk("t3 vy clamped", last_vy, 8);
        chk("t3 score0", int'(score0), 1);
        chk("t3 player kept", int'(currentPlayer), 0);

        // 4: both pocketed is a foul
        shoot(4, 4);
        roll(0, 1, 1, 2, 0, -1);
        tick();
        chk("t4 score0", int'(score0), 1);
        chk("t4 score1", int'(score1), 0);
        chk("t4 player", int'(currentPlayer), 1);

        // 5: never still -> frame timeout
        shoot(1, 1);
        roll(100000, 0, 0, 0, 0, -1);
        tick();
        chk("t5 player", int'(currentPlayer), 0);

        // 6: reach the winning score, then restart
        shoot(2, 2);
        roll(1, 0, 1, 4, 0, -1);
        tick();
        chk("t6 score0 2", int'(score0), 2);
        shoot(2, 2);
        roll(1, 0, 1, 4, 0, -1);
        repeat (3) tick();
        chk("t6 score0 3", int'(score0), 3);
        chk("t6 gameOver", int'(gameOver), 1);
        chk("t6 aim off", int'(aimEnable), 0);
        restart_game();
        chk("restart score0", int'(score0), 0);
        chk("restart gameOver", int'(gameOver), 0);

        // reset mid-ROLLING with red hidden
        shoot(5, 0);
        roll(1, 0, 1, 4, 0, -1);
        tick();
        chk("pre-reset score0", int'(score0), 1);
        shoot(5, 0);
        roll(1, 0, 1, 2, 0, 12);
        chk("redHide mid roll", int'(redHide), 1);
        do_reset(2);
        chk("post reset score0", int'(score0), 0);
        chk("post reset redHide", int'(redHide), 0);
        chk("post reset aim", int'(aimEnable), 1);
        repeat (10) tick();

        // reset during the FIRE cycle suppresses the load pulse
        saved   = n_loads;
        cueVelX = 11'sd6;
        cueVelY = 11'sd6;
        shotReq = 1'b1;
        tick();
        m_valid = 1'b0;
        reset   = 1'b1;
        shotReq = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        m_valid = 1'b1;
        repeat (4) tick();
        chk("no load under reset", n_loads, saved);
        chk("aim after fire reset", int'(aimEnable), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
